// File: rtl/pacman_pkg.sv
// Shared constants for the pacman video pipeline: font geometry, character codes and palette.
package pacman_pkg;

    localparam int unsigned FONT_W      = 8;
    localparam int unsigned FONT_H      = 8;
    localparam logic [6:0]  FONT_FIRST  = 7'h20;
    localparam int unsigned FONT_GLYPHS = 64;
    localparam logic [6:0]  CHAR_SPACE  = 7'h20;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
    localparam logic [11:0] COLOR_YELLOW = 12'hFF0;
    localparam logic [11:0] COLOR_RED    = 12'hF00;
    localparam logic [11:0] COLOR_CYAN   = 12'h0FF;

    function automatic logic code_has_glyph(input logic [6:0] code);
        return (code >= FONT_FIRST) && (code < (FONT_FIRST + 7'(FONT_GLYPHS)));
    endfunction

    function automatic logic [5:0] glyph_index(input logic [6:0] code);
        return 6'(code - FONT_FIRST);
    endfunction

endpackage

// File: rtl/text_overlay_renderer_font_rom.sv
// 64-glyph 8x8 font (ASCII 0x20..0x5F), 5x7 strokes in bits 6..2, synchronous row read, bit7 = leftmost.
module font_rom
    import pacman_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] glyph_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    logic [34:0] glyph_s;
    logic [4:0]  row5_s;
    logic [7:0]  bits_d;
    logic [7:0]  bits_q;

    // Each entry packs rows 0..6 top-down, five pixels per row; row 7 is always blank.
    function automatic logic [34:0] glyph_rows(input logic [5:0] idx);
        case (idx)
            6'h00: glyph_rows = 35'b00000_00000_00000_00000_00000_00000_00000;
            6'h01: glyph_rows = 35'b00100_00100_00100_00100_00100_00000_00100;
            6'h02: glyph_rows = 35'b01010_01010_01010_00000_00000_00000_00000;
            6'h03: glyph_rows = 35'b01010_01010_11111_01010_11111_01010_01010;
            6'h04: glyph_rows = 35'b00100_01111_10100_01110_00101_11110_00100;
            6'h05: glyph_rows = 35'b11000_11001_00010_00100_01000_10011_00011;
            6'h06: glyph_rows = 35'b01100_10010_10100_01000_10101_10010_01101;
            6'h07: glyph_rows = 35'b01100_00100_01000_00000_00000_00000_00000;
            6'h08: glyph_rows = 35'b00010_00100_01000_01000_01000_00100_00010;
            6'h09: glyph_rows = 35'b01000_00100_00010_00010_00010_00100_01000;
            6'h0A: glyph_rows = 35'b00000_00100_10101_01110_10101_00100_00000;
            6'h0B: glyph_rows = 35'b00000_00100_00100_11111_00100_00100_00000;
            6'h0C: glyph_rows = 35'b00000_00000_00000_00000_01100_00100_01000;
            6'h0D: glyph_rows = 35'b00000_00000_00000_11111_00000_00000_00000;
            6'h0E: glyph_rows = 35'b00000_00000_00000_00000_00000_01100_01100;
            6'h0F: glyph_rows = 35'b00000_00001_00010_00100_01000_10000_00000;
            6'h10: glyph_rows = 35'b01110_10001_10011_10101_11001_10001_01110;
            6'h11: glyph_rows = 35'b00100_01100_00100_00100_00100_00100_01110;
            6'h12: glyph_rows = 35'b01110_10001_00001_00010_00100_01000_11111;
            6'h13: glyph_rows = 35'b11111_00010_00100_00010_00001_10001_01110;
            6'h14: glyph_rows = 35'b00010_00110_01010_10010_11111_00010_00010;
            6'h15: glyph_rows = 35'b11111_10000_11110_00001_00001_10001_01110;
            6'h16: glyph_rows = 35'b00110_01000_10000_11110_10001_10001_01110;
            6'h17: glyph_rows = 35'b11111_00001_00010_00100_01000_01000_01000;
            6'h18: glyph_rows = 35'b01110_10001_10001_01110_10001_10001_01110;
            6'h19: glyph_rows = 35'b01110_10001_10001_01111_00001_00010_01100;
            6'h1A: glyph_rows = 35'b00000_01100_01100_00000_01100_01100_00000;
            6'h1B: glyph_rows = 35'b00000_01100_01100_00000_01100_00100_01000;
            6'h1C: glyph_rows = 35'b00010_00100_01000_10000_01000_00100_00010;
            6'h1D: glyph_rows = 35'b00000_00000_11111_00000_11111_00000_00000;
            6'h1E: glyph_rows = 35'b01000_00100_00010_00001_00010_00100_01000;
            6'h1F: glyph_rows = 35'b01110_10001_00001_00010_00100_00000_00100;
            6'h20: glyph_rows = 35'b01110_10001_00001_01101_10101_10101_01110;
            6'h21: glyph_rows = 35'b01110_10001_10001_10001_11111_10001_10001;
            6'h22: glyph_rows = 35'b11110_10001_10001_11110_10001_10001_11110;
            6'h23: glyph_rows = 35'b01110_10001_10000_10000_10000_10001_01110;
            6'h24: glyph_rows = 35'b11100_10010_10001_10001_10001_10010_11100;
            6'h25: glyph_rows = 35'b11111_10000_10000_11110_10000_10000_11111;
            6'h26: glyph_rows = 35'b11111_10000_10000_11110_10000_10000_10000;
            6'h27: glyph_rows = 35'b01110_10001_10000_10111_10001_10001_01111;
            6'h28: glyph_rows = 35'b10001_10001_10001_11111_10001_10001_10001;
            6'h29: glyph_rows = 35'b01110_00100_00100_00100_00100_00100_01110;
            6'h2A: glyph_rows = 35'b00111_00010_00010_00010_00010_10010_01100;
            6'h2B: glyph_rows = 35'b10001_10010_10100_11000_10100_10010_10001;
            6'h2C: glyph_rows = 35'b10000_10000_10000_10000_10000_10000_11111;
            6'h2D: glyph_rows = 35'b10001_11011_10101_10101_10001_10001_10001;
            6'h2E: glyph_rows = 35'b10001_10001_11001_10101_10011_10001_10001;
            6'h2F: glyph_rows = 35'b01110_10001_10001_10001_10001_10001_01110;
            6'h30: glyph_rows = 35'b11110_10001_10001_11110_10000_10000_10000;
            6'h31: glyph_rows = 35'b01110_10001_10001_10001_10101_10010_01101;
            6'h32: glyph_rows = 35'b11110_10001_10001_11110_10100_10010_10001;
            6'h33: glyph_rows = 35'b01111_10000_10000_01110_00001_00001_11110;
            6'h34: glyph_rows = 35'b11111_00100_00100_00100_00100_00100_00100;
            6'h35: glyph_rows = 35'b10001_10001_10001_10001_10001_10001_01110;
            6'h36: glyph_rows = 35'b10001_10001_10001_10001_10001_01010_00100;
            6'h37: glyph_rows = 35'b10001_10001_10001_10101_10101_10101_01010;
            6'h38: glyph_rows = 35'b10001_10001_01010_00100_01010_10001_10001;
            6'h39: glyph_rows = 35'b10001_10001_10001_01010_00100_00100_00100;
            6'h3A: glyph_rows = 35'b11111_00001_00010_00100_01000_10000_11111;
            6'h3B: glyph_rows = 35'b01110_01000_01000_01000_01000_01000_01110;
            6'h3C: glyph_rows = 35'b00000_10000_01000_00100_00010_00001_00000;
            6'h3D: glyph_rows = 35'b01110_00010_00010_00010_00010_00010_01110;
            6'h3E: glyph_rows = 35'b00100_01010_10001_00000_00000_00000_00000;
            6'h3F: glyph_rows = 35'b00000_00000_00000_00000_00000_00000_11111;
            default: glyph_rows = 35'd0;
        endcase
    endfunction

    always_comb begin
        glyph_s = glyph_rows(glyph_i);
        case (row_i)
            3'd0:    row5_s = glyph_s[34:30];
            3'd1:    row5_s = glyph_s[29:25];
            3'd2:    row5_s = glyph_s[24:20];
            3'd3:    row5_s = glyph_s[19:15];
            3'd4:    row5_s = glyph_s[14:10];
            3'd5:    row5_s = glyph_s[9:5];
            3'd6:    row5_s = glyph_s[4:0];
            default: row5_s = 5'd0;
        endcase
        bits_d = {1'b0, row5_s, 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= 8'h00;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign bits_o = bits_q;

endmodule

// File: rtl/text_overlay_renderer.sv
// Scaled bitmap-text overlay: writable character grid rendered at a runtime origin,
// three-stage pixel pipeline (geometry -> grid read + font row -> bit select) with frame blink.
module text_overlay_renderer
    import pacman_pkg::*;
#(
    parameter int unsigned FONT_SCALE_LOG2 = 1,
    parameter int unsigned N_COLS          = 16,
    parameter int unsigned N_ROWS          = 2,
    parameter int unsigned COORD_W         = 10,
    parameter int unsigned COLOR_W         = 12,
    parameter int unsigned BLINK_FRAMES    = 30,
    localparam int unsigned AW             = $clog2(N_COLS * N_ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic               frame_start_i,
    input  logic [COORD_W-1:0] origin_x_i,
    input  logic [COORD_W-1:0] origin_y_i,
    input  logic [COLOR_W-1:0] fg_color_i,
    input  logic               blink_en_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [6:0]         wr_data_i,
    output logic               valid_o,
    output logic               text_on_o,
    output logic [COLOR_W-1:0] text_color_o
);

    localparam int unsigned S       = FONT_SCALE_LOG2;
    localparam int unsigned XW      = COORD_W + 1;
    localparam int unsigned N_CELLS = N_COLS * N_ROWS;
    localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [XW-1:0]    SPAN_X     = XW'((N_COLS * FONT_W) << S);
    localparam logic [XW-1:0]    SPAN_Y     = XW'((N_ROWS * FONT_H) << S);
    localparam logic [XW-1:0]    COLS_W     = XW'(N_COLS);
    localparam logic [AW:0]      CELLS_W    = (AW + 1)'(N_CELLS);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [XW-1:0] rel_x_s, rel_y_s, col_s, row_s;
    logic [AW-1:0] cell_addr_s;
    logic          inside_s;

    logic          s0_valid_d, s0_valid_q, s0_inside_d, s0_inside_q;
    logic [AW-1:0] s0_addr_d, s0_addr_q;
    logic [2:0]    s0_gx_d, s0_gx_q, s0_gy_d, s0_gy_q;

    logic [6:0]    code_s;
    logic          s1_valid_d, s1_valid_q, s1_lit_d, s1_lit_q;
    logic [2:0]    s1_gx_d, s1_gx_q;
    logic [7:0]    rom_bits_s;

    logic               valid_d, valid_q, text_on_d, text_on_q;
    logic [COLOR_W-1:0] color_d, color_q;

    logic [CNT_W-1:0] blink_cnt_d, blink_cnt_q;
    logic             blink_phase_d, blink_phase_q;
    logic [6:0]       grid_d [N_CELLS];
    logic [6:0]       grid_q [N_CELLS];

    // Geometry is computed one bit wider than the coordinates so a pixel left of/above the origin can't alias inside.
    always_comb begin
        rel_x_s     = {1'b0, pix_x_i} - {1'b0, origin_x_i};
        rel_y_s     = {1'b0, pix_y_i} - {1'b0, origin_y_i};
        inside_s    = (pix_x_i >= origin_x_i) && (pix_y_i >= origin_y_i) &&
                      (rel_x_s < SPAN_X) && (rel_y_s < SPAN_Y);
        col_s       = rel_x_s >> (3 + S);
        row_s       = rel_y_s >> (3 + S);
        cell_addr_s = AW'(row_s * COLS_W + col_s);
        s0_valid_d  = pix_valid_i;
        s0_inside_d = inside_s;
        s0_addr_d   = cell_addr_s;
        s0_gx_d     = rel_x_s[S+2:S];
        s0_gy_d     = rel_y_s[S+2:S];
    end

    // Grid read is combinational against the pre-edge contents, so a same-cycle write is seen only next time.
    always_comb begin
        if ({1'b0, s0_addr_q} < CELLS_W) begin
            code_s = grid_q[s0_addr_q];
        end else begin
            code_s = CHAR_SPACE;
        end
        s1_valid_d = s0_valid_q;
        s1_lit_d   = s0_inside_q & code_has_glyph(code_s);
        s1_gx_d    = s0_gx_q;
    end

    font_rom u_font_rom (
        .clk     (clk),
        .rst_n   (rst_n),
        .glyph_i (glyph_index(code_s)),
        .row_i   (s0_gy_q),
        .bits_o  (rom_bits_s)
    );

    always_comb begin
        valid_d   = s1_valid_q;
        text_on_d = s1_valid_q & s1_lit_q & rom_bits_s[3'd7 - s1_gx_q] &
                    ~(blink_en_i & blink_phase_q);
        if (text_on_d) begin
            color_d = fg_color_i;
        end else begin
            color_d = {COLOR_W{1'b0}};
        end
    end

    // Character writes and the frame-counted blink phase.
    always_comb begin
        grid_d = grid_q;
        if (wr_en_i && ({1'b0, wr_addr_i} < CELLS_W)) begin
            grid_d[wr_addr_i] = wr_data_i;
        end else begin
            grid_d = grid_q;
        end
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start_i) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = {CNT_W{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + CNT_W'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q    <= 1'b0;
            s0_inside_q   <= 1'b0;
            s0_addr_q     <= {AW{1'b0}};
            s0_gx_q       <= 3'd0;
            s0_gy_q       <= 3'd0;
            s1_valid_q    <= 1'b0;
            s1_lit_q      <= 1'b0;
            s1_gx_q       <= 3'd0;
            valid_q       <= 1'b0;
            text_on_q     <= 1'b0;
            color_q       <= {COLOR_W{1'b0}};
            blink_cnt_q   <= {CNT_W{1'b0}};
            blink_phase_q <= 1'b0;
            for (int i = 0; i < int'(N_CELLS); i++) begin
                grid_q[i] <= CHAR_SPACE;
            end
        end else begin
            s0_valid_q    <= s0_valid_d;
            s0_inside_q   <= s0_inside_d;
            s0_addr_q     <= s0_addr_d;
            s0_gx_q       <= s0_gx_d;
            s0_gy_q       <= s0_gy_d;
            s1_valid_q    <= s1_valid_d;
            s1_lit_q      <= s1_lit_d;
            s1_gx_q       <= s1_gx_d;
            valid_q       <= valid_d;
            text_on_q     <= text_on_d;
            color_q       <= color_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            grid_q        <= grid_d;
        end
    end

    assign valid_o      = valid_q;
    assign text_on_o    = text_on_q;
    assign text_color_o = color_q;

endmodule
